uart_tx_engine: RTL and testbench

- Serial UART transmitter; converts one parallel byte into an 8-N-1 frame on `TXD`, or 8-E-1 when parity is compiled in.
- Sits next to the UART receive path in the PC↔FPGA UART design and is driven by the same user logic that consumes received bytes, so received data can be echoed back.
- Owns its bit-rate generator: a 32-bit phase accumulator using the same `BPS_CNT` scaling as the receive side.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/tx_bps_gen.sv | 27 ++
 rtl/uart_tx_engine.sv | 126 ++++++++++++
 tb/tb_uart_tx_engine.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths
// (state encoding, 2^32*baud/f_clk increments, frame data width).
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Phase-accumulator increments, round(2^32 * baud / f_clk)
  localparam logic [31:0] BPS_9600_50M    = 32'd824634;
  localparam logic [31:0] BPS_115200_50M  = 32'd9895605;
  localparam logic [31:0] BPS_128000_50M  = 32'd10995116;
  localparam logic [31:0] BPS_256000_50M  = 32'd21990233;
  localparam logic [31:0] BPS_9600_100M   = 32'd412317;
  localparam logic [31:0] BPS_115200_100M = 32'd4947802;
  localparam logic [31:0] BPS_128000_100M = 32'd5497558;
  localparam logic [31:0] BPS_256000_100M = 32'd10995116;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/tx_bps_gen.sv
// tx_bps_gen: 32-bit phase accumulator; BPS_CLKen is the carry out of the
// running sum, so bit periods alternate between floor/ceil of 2^32/BPS_CNT.
module tx_bps_gen #(
  parameter logic [31:0] BPS_CNT = 32'd824634
) (
  input  logic CLOCK,
  input  logic En_Sig,
  input  logic Clr_Sig,
  output logic BPS_CLKen
);

  logic [31:0] acc_p0;
  logic [32:0] sum;

  assign sum       = {1'b0, acc_p0} + {1'b0, BPS_CNT};
  assign BPS_CLKen = En_Sig & sum[32];

  // Only the 32-bit remainder is kept so the fractional phase carries over.
  always_ff @(posedge CLOCK) begin
    if (Clr_Sig) begin
      acc_p0 <= '0;
    end else if (En_Sig) begin
      acc_p0 <= sum[31:0];
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: byte-to-serial UART transmitter, 8-N-1 by default.
// Define UART_TX_PARITY_EN for 8-E-1 framing; it must match the receive side.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter logic [31:0] BPS_CNT = 32'd824634
) (
  input  logic                   CLOCK,
  input  logic                   RST,
  input  logic                   TX_En_Sig,
  input  logic [UART_DATA_W-1:0] TX_Data,
  output logic                   TXD,
  output logic                   TX_Busy,
  output logic                   TX_Done_Sig
);

  tx_state_t              state_p0, state_nxt;
  logic [UART_DATA_W-1:0] shift_p0, shift_nxt;
  logic [2:0]             cnt_p0, cnt_nxt;
  logic                   accept, tick, bps_en, bps_clr;
  logic                   txd_nxt, done_nxt;
`ifdef UART_TX_PARITY_EN
  logic                   par_p0, par_nxt;
`endif

  assign bps_en  = (state_p0 != IDLE);
  assign bps_clr = RST | accept;

  tx_bps_gen #(
    .BPS_CNT (BPS_CNT)
  ) u_bps_gen (
    .CLOCK     (CLOCK),
    .En_Sig    (bps_en),
    .Clr_Sig   (bps_clr),
    .BPS_CLKen (tick)
  );

  always_comb begin
    state_nxt = state_p0;
    shift_nxt = shift_p0;
    cnt_nxt   = cnt_p0;
    accept    = 1'b0;
    done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par_p0;
`endif

    case (state_p0)
      IDLE: begin
        if (TX_En_Sig) begin
          accept    = 1'b1;
          state_nxt = START;
          shift_nxt = TX_Data;
          cnt_nxt   = 3'd0;
`ifdef UART_TX_PARITY_EN
          par_nxt   = ^TX_Data;
`endif
        end
      end
      START: begin
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_nxt = {1'b0, shift_p0[UART_DATA_W-1:1]};
          cnt_nxt   = cnt_p0 + 3'd1;
          if (cnt_p0 == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Line level is decoded from the next state so TXD leaves a flop.
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_nxt = par_nxt;
`endif
      default: txd_nxt = 1'b1;
    endcase
  end

  // ---- control register stage ----
  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state_p0    <= IDLE;
      cnt_p0      <= 3'd0;
      TXD         <= 1'b1;
      TX_Busy     <= 1'b0;
      TX_Done_Sig <= 1'b0;
    end else begin
      state_p0    <= state_nxt;
      cnt_p0      <= cnt_nxt;
      TXD         <= txd_nxt;
      TX_Busy     <= (state_nxt != IDLE);
      TX_Done_Sig <= done_nxt;
    end
  end

  // ---- data register stage ----
  always_ff @(posedge CLOCK) begin
    shift_p0 <= shift_nxt;
`ifdef UART_TX_PARITY_EN
    par_p0   <= par_nxt;
`endif
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed bench with a frame-decoding scoreboard for
// uart_tx_engine; follows UART_TX_PARITY_EN for the expected frame length.
module tb_uart_tx_engine;
  import uart_pkg::*;

  localparam logic [31:0] BPS_A   = 32'h2000_0000;
  localparam logic [31:0] BPS_R   = 32'd824634;
  localparam int          BIT_CYC = 8;
`ifdef UART_TX_PARITY_EN
  localparam int          NB      = 11;
`else
  localparam int          NB      = 10;
`endif
  localparam int          DONE_CYC = BIT_CYC * NB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [UART_DATA_W-1:0] data = '0;
  logic txd, busy, done;
  logic en_r = 1'b0;
  logic [UART_DATA_W-1:0] data_r = '0;
  logic txd_r, busy_r, done_r;

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [7:0] q[$];
  logic [7:0] q_r[$];

  uart_tx_engine #(.BPS_CNT(BPS_A)) dut (
    .CLOCK(clk), .RST(rst), .TX_En_Sig(en), .TX_Data(data),
    .TXD(txd), .TX_Busy(busy), .TX_Done_Sig(done)
  );

  uart_tx_engine #(.BPS_CNT(BPS_R)) dut_r (
    .CLOCK(clk), .RST(rst), .TX_En_Sig(en_r), .TX_Data(data_r),
    .TXD(txd_r), .TX_Busy(busy_r), .TX_Done_Sig(done_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start, data LSB first, [even parity], stop.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic start_frame(input logic [7:0] b, input bit expect_out);
    en   = 1'b1;
    data = b;
    if (expect_out) q.push_back(b);
    @(negedge clk);
    en   = 1'b0;
    data = ~b;
  endtask

  task automatic check_frame(input logic [7:0] b, input int ign_cyc,
                             input bit chain, input logic [7:0] b2);
    for (int c = 1; c < DONE_CYC; c++) begin
      chk($sformatf("frame_%02h_c%0d", b, c), 32'({txd, busy, done}),
          32'({frame_bit(b, (c - 1) / BIT_CYC), 2'b10}));
      if (c == ign_cyc) begin
        en   = 1'b1;
        data = 8'h00;
      end else if (c == ign_cyc + 1) begin
        en   = 1'b0;
        data = ~b;
      end
      @(negedge clk);
    end
    chk($sformatf("done_cycle_%02h", b), 32'({txd, busy, done}), 32'(3'b101));
    if (chain) begin
      en   = 1'b1;
      data = b2;
      q.push_back(b2);
      @(negedge clk);
      en   = 1'b0;
      data = ~b2;
    end else begin
      @(negedge clk);
      chk($sformatf("after_done_%02h", b), 32'({txd, busy, done}), 32'(3'b100));
    end
  endtask

  // Scoreboard: decode DUT frames mid-bit and compare against queued bytes.
  initial begin : monitor
    int fc;
    bit in_frame;
    logic [10:0] bits;
    logic [7:0] exp_b;
    fc = 0;
    in_frame = 1'b0;
    bits = '0;
    forever begin
      @(posedge clk);
      #2;
      if (done === 1'b1) done_cnt++;
      if (rst) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (txd === 1'b0) begin
          in_frame = 1'b1;
          fc = 1;
        end
      end else begin
        fc++;
      end
      if (in_frame && (fc % BIT_CYC) == (BIT_CYC / 2 + 1)) begin
        bits[(fc - 1) / BIT_CYC] = txd;
        if ((fc - 1) / BIT_CYC == NB - 1) begin
          in_frame = 1'b0;
          if (q.size() != 0) exp_b = q.pop_front();
          else exp_b = 8'hxx;
          chk("sb_data", 32'(bits[8:1]), 32'(exp_b));
`ifdef UART_TX_PARITY_EN
          chk("sb_parity", 32'(bits[9]), 32'(^exp_b));
`endif
          chk("sb_stop", 32'(bits[NB-1]), 32'd1);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    longint unsigned nk [0:NB];
    int mis;
    logic fbit;
    logic [NB-1:0] rx;
    logic [7:0] exp_r;

    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset", 32'({txd, busy, done}), 32'(3'b100));
      chk("reset_r", 32'({txd_r, busy_r, done_r}), 32'(3'b100));
    end
    rst = 1'b0;
    @(negedge clk);

    start_frame(8'hA5, 1'b1);
    check_frame(8'hA5, 0, 1'b0, 8'h00);

    start_frame(8'h3C, 1'b1);
    check_frame(8'h3C, 0, 1'b1, 8'hFF);
    check_frame(8'hFF, 0, 1'b0, 8'h00);

    start_frame(8'h81, 1'b1);
    check_frame(8'h81, 30, 1'b0, 8'h00);

    // Abort a frame at cycle 40; it must never show up at the scoreboard.
    start_frame(8'hC3, 1'b0);
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_frame", 32'({txd, busy, done}), 32'(3'b100));
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("post_abort_idle_%0d", i), 32'({txd, busy, done}), 32'(3'b100));
    end

    start_frame(8'h55, 1'b1);
    check_frame(8'h55, 0, 1'b0, 8'h00);
    repeat (4) @(negedge clk);

    // Real rate: bit k ends on the ceil(k*2^32/BPS)-th accumulator add.
    for (int k = 0; k <= NB; k++)
      nk[k] = ((64'(k) << 32) + 64'(BPS_R) - 64'd1) / 64'(BPS_R);
    en_r   = 1'b1;
    data_r = 8'h4B;
    q_r.push_back(8'h4B);
    @(negedge clk);
    en_r   = 1'b0;
    data_r = 8'h00;
    rx = '0;
    for (int k = 0; k < NB; k++) begin
      mis  = 0;
      fbit = frame_bit(8'h4B, k);
      for (longint unsigned j = nk[k] + 1; j <= nk[k+1]; j++) begin
        if ({txd_r, busy_r, done_r} !== {fbit, 2'b10}) mis++;
        if (j == (nk[k] + nk[k+1] + 1) / 2) rx[k] = txd_r;
        @(negedge clk);
      end
      chk($sformatf("rate_bit%0d", k), 32'(mis), 32'd0);
    end
    chk("rate_done", 32'({txd_r, busy_r, done_r}), 32'(3'b101));
    exp_r = q_r.pop_front();
    chk("rate_loopback", 32'(rx[8:1]), 32'(exp_r));
    chk("rate_stop", 32'(rx[NB-1]), 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_queue_empty", 32'(q.size()), 32'd0);
    chk("done_pulse_count", 32'(done_cnt), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
